// File: rtl/max_subtract_buffer_pkg.sv
// Shared Q7.8 softmax definitions: word width, saturation bounds, the
// buffer FSM state encoding and the 17-to-16-bit saturating narrower.
package softmax_pkg;

  localparam int          Q78_W       = 16;
  localparam logic [15:0] Q78_NEG_INF = 16'h8000;
  localparam logic [15:0] Q78_MAX     = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_WAIT_MAX = 2'd1,
    ST_DRAIN    = 2'd2
  } sm_state_e;

  // Narrow a 17-bit signed difference to Q7.8, saturating on overflow.
  function automatic logic signed [Q78_W-1:0] sat16(input logic signed [Q78_W:0] d);
    logic signed [Q78_W-1:0] r;
    if (d[Q78_W] != d[Q78_W-1]) begin
      r = d[Q78_W] ? $signed(Q78_NEG_INF) : $signed(Q78_MAX);
    end else begin
      r = d[Q78_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_vec_ram.sv
// Simple dual-port synchronous vector RAM: one write port, one read port
// with one cycle of read latency. The read register only updates on re,
// so the last read word stays on rdata while the consumer is stalled.
module sm_vec_ram
  import softmax_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [Q78_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [Q78_W-1:0] rdata
);

  logic [Q78_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, held while re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/max_subtract_buffer.sv
// Buffers one Q7.8 vector while the max detector scans it, then replays it
// as x - xmax (17-bit subtract, saturated to Q7.8) once the max arrives.
// Optional build macro: MAX_SUB_CLAMP_EN -- floors every difference at
// CLAMP_Q78 so very negative exponent arguments stay in a bounded range.
module max_subtract_buffer
  import softmax_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [15:0] CLAMP_Q78 = 16'hF000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        max_valid,
  input  logic [15:0] max_q78,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic signed [Q78_W-1:0] clamp_lo(input logic signed [Q78_W-1:0] v);
    return (v < $signed(CLAMP_Q78)) ? $signed(CLAMP_Q78) : v;
  endfunction

  sm_state_e               state;
  logic [AW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           rd_ptr;
  logic signed [Q78_W-1:0] xmax;
  logic                    err_ovf_q;

  logic                    vld_p1;
  logic                    last_p1;
  logic [Q78_W-1:0]        ram_q_p1;
  logic signed [Q78_W:0]   diff_p1;
  logic signed [Q78_W-1:0] res_p1;

  logic                    vld_p2;
  logic [Q78_W-1:0]        data_p2;
  logic                    last_p2;

  logic wr_fire, wr_is_last, capture, out_fire;
  logic load_p2, p1_free, rd_issue, rd_issue_last;

  assign in_ready      = (state == ST_FILL);
  assign wr_fire       = in_valid && in_ready;
  assign wr_is_last    = in_last || (wr_ptr == AW'(DEPTH - 1));
  assign capture       = (state == ST_WAIT_MAX) && max_valid;
  assign out_fire      = vld_p2 && out_ready;
  assign load_p2       = vld_p1 && (!vld_p2 || out_ready);
  assign p1_free       = !vld_p1 || load_p2;
  assign rd_issue      = (capture || (state == ST_DRAIN)) && (rd_ptr < count) && p1_free;
  assign rd_issue_last = (rd_ptr == (count - CW'(1)));

  sm_vec_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (rd_issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q_p1)
  );

  // ---- stage p1: RAM word minus captured max, saturated (and optionally floored)
  assign diff_p1 = $signed({ram_q_p1[Q78_W-1], ram_q_p1}) - $signed({xmax[Q78_W-1], xmax});
`ifdef MAX_SUB_CLAMP_EN
  assign res_p1 = clamp_lo(sat16(diff_p1));
`else
  assign res_p1 = sat16(diff_p1);
`endif

  // FSM, write/read pointers, max capture and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      wr_ptr    <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      xmax      <= $signed(Q78_NEG_INF);
      err_ovf_q <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + CW'(1);
      case (state)
        ST_FILL: begin
          if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_is_last) begin
              count <= {1'b0, wr_ptr} + CW'(1);
              state <= ST_WAIT_MAX;
              if (!in_last) err_ovf_q <= 1'b1;
            end
          end
        end
        ST_WAIT_MAX: begin
          if (max_valid) begin
            xmax  <= $signed(max_q78);
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_fire && last_p2) begin
            state  <= ST_FILL;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Read-data valid flag: set by a read, cleared when the word moves to p2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (rd_issue) begin
      vld_p1 <= 1'b1;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  // Last-element tag travelling with each read
  always_ff @(posedge clk) begin
    if (rd_issue) last_p1 <= rd_issue_last;
  end

  // ---- stage p2: registered output beat, held while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (load_p2) begin
      vld_p2  <= 1'b1;
      data_p2 <= res_p1;
      last_p2 <= last_p1;
    end else if (out_fire) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_last  = last_p2;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_max_subtract_buffer.sv
// Directed bench for max_subtract_buffer (DEPTH=8) with hand-computed vectors.
module tb_max_subtract_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        max_valid;
  logic [15:0] max_q78;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        err_ovf;

  int n_cmp = 0;
  int n_err = 0;
  int acc;

  logic [15:0] vin  [16];
  logic [15:0] vexp [16];
  int          pat  [5] = '{1, 0, 0, 1, 0};

  always #5 clk = ~clk;

  max_subtract_buffer #(.DEPTH(DEPTH), .CLAMP_Q78(16'hF000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .max_valid (max_valid),
    .max_q78   (max_q78),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err_ovf   (err_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i];
      in_last  = with_last && (i == n - 1);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_max(input logic [15:0] m);
    max_valid = 1'b1;
    max_q78   = m;
    step();
    max_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int mode, input string tag);
    int          got;
    bit          hold;
    logic [15:0] held_d;
    logic        held_l;
    logic        rdy;
    got  = 0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : pat[cyc % 5][0];
      out_ready = rdy;
      if (hold) begin
        check({tag, "_hold_vld"},  {31'd0, out_valid}, 32'd1);
        check({tag, "_hold_data"}, {16'd0, out_data},  {16'd0, held_d});
        check({tag, "_hold_last"}, {31'd0, out_last},  {31'd0, held_l});
      end
      if (out_valid && rdy) begin
        check($sformatf("%s_data%0d", tag, got), {16'd0, out_data}, {16'd0, vexp[got]});
        check($sformatf("%s_last%0d", tag, got), {31'd0, out_last}, {31'd0, (got == n - 1)});
        got++;
      end
      hold   = out_valid && !rdy;
      held_d = out_data;
      held_l = out_last;
      step();
      if (got >= n) break;
    end
    out_ready = 1'b1;
    check({tag, "_beats"},     got,                 n);
    check({tag, "_no_dup"},    {31'd0, out_valid},  32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    max_valid = 1'b0;
    max_q78   = '0;
    out_ready = 1'b1;
    acc       = 0;

    // Reset state
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_err_ovf",   {31'd0, err_ovf},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;
    step();

    // max_valid during FILL is ignored
    pulse_max(16'h1000);
    check("fill_max_ign_rdy", {31'd0, in_ready}, 32'd1);
    vin[0] = 16'h0300; vin[1] = 16'h0100;
    send(2, 1'b1);
    check("wait_max_rdy", {31'd0, in_ready}, 32'd0);
    step();
    step();
    check("wait_no_out", {31'd0, out_valid}, 32'd0);
    pulse_max(16'h0300);
    vexp[0] = 16'h0000; vexp[1] = 16'hFE00;
    drain(2, 0, "t_ign");

    // Basic vector and first-output latency
    vin[0] = 16'h0100; vin[1] = 16'h0200; vin[2] = 16'hFF80; vin[3] = 16'h0200;
    send(4, 1'b1);
    pulse_max(16'h0200);
    check("lat_cap_plus1", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_cap_plus2", {31'd0, out_valid}, 32'd1);
    vexp[0] = 16'hFF00; vexp[1] = 16'h0000; vexp[2] = 16'hFD80; vexp[3] = 16'h0000;
    drain(4, 0, "t_basic");

    // Single element, negative saturation (and optional clamp)
    vin[0] = 16'h8000;
    send(1, 1'b1);
    pulse_max(16'h7FFF);
`ifdef MAX_SUB_CLAMP_EN
    vexp[0] = 16'hF000;
`else
    vexp[0] = 16'h8000;
`endif
    drain(1, 0, "t_single");

    // Back-pressure pattern 1,0,0,1,0
    vin[0] = 16'h0010; vin[1] = 16'h0020; vin[2] = 16'h0030; vin[3] = 16'h0040;
    send(4, 1'b1);
    pulse_max(16'h0040);
    vexp[0] = 16'hFFD0; vexp[1] = 16'hFFE0; vexp[2] = 16'hFFF0; vexp[3] = 16'h0000;
    drain(4, 1, "t_stall");

    // Overflow: 10 beats, no in_last, DEPTH=8
    for (int i = 0; i < 10; i++) vin[i] = 16'((i + 1) * 16);
    acc = 0;
    send(10, 1'b0);
    check("ovf_accepted", acc, 8);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_err",      {31'd0, err_ovf},  32'd1);
    pulse_max(16'h0080);
    vexp[0] = 16'hFF90; vexp[1] = 16'hFFA0; vexp[2] = 16'hFFB0; vexp[3] = 16'hFFC0;
    vexp[4] = 16'hFFD0; vexp[5] = 16'hFFE0; vexp[6] = 16'hFFF0; vexp[7] = 16'h0000;
    drain(8, 0, "t_ovf");
    check("ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // Reset mid-DRAIN abandons the vector
    vin[0] = 16'h0100; vin[1] = 16'h0200; vin[2] = 16'h0300; vin[3] = 16'h0400;
    send(4, 1'b1);
    pulse_max(16'h0400);
    step();
    check("mid_beat1_vld",  {31'd0, out_valid}, 32'd1);
    check("mid_beat1_data", {16'd0, out_data},  32'h0000FD00);
    step();
    check("mid_beat2_data", {16'd0, out_data},  32'h0000FE00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_vld",   {31'd0, out_valid}, 32'd0);
    check("mid_rst_data",  {16'd0, out_data},  32'd0);
    check("mid_rst_last",  {31'd0, out_last},  32'd0);
    check("mid_rst_err",   {31'd0, err_ovf},   32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    step();
    step();
    check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
    vin[0] = 16'h7FFF; vin[1] = 16'h9000;
    send(2, 1'b1);
    pulse_max(16'h8000);
    vexp[0] = 16'h7FFF; vexp[1] = 16'h1000;
    drain(2, 0, "t_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/max_subtract_buffer.md
MAX_SUBTRACT_BUFFER -- requirements
Module: max_subtract_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning maximum vector length in elements (power of two, ≥4).
REQ-002 SHALL have parameter CLAMP_Q78, default 16'hF000 (-16.0), meaning lower clamp bound used only under REQ-024.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have ports in_valid / in_data[15:0] / in_last / in_ready (in_ready is the output) for the Q7.8 signed element stream, in parallel with the max-detector input.
REQ-006 SHALL have ports max_valid (1-cycle pulse) and max_q78[15:0], both inputs, driven by the max detector's vec_done and xmax_q78.
REQ-007 SHALL have ports out_valid, out_data[15:0], out_last (outputs) and out_ready (input) for the Q7.8 stream of x - xmax.
REQ-008 SHALL have port err_ovf, output, 1, meaning a sticky vector-overflow flag.

Function
REQ-009 SHALL implement FSM states FILL, WAIT_MAX and DRAIN; reset state is FILL.
REQ-010 In FILL: in_ready=1; each in_valid beat is written at wr_ptr, which then increments.
REQ-011 Accepting an in_last beat SHALL move the FSM to WAIT_MAX with count = wr_ptr+1.
REQ-012 If DEPTH beats are accepted without in_last, the DEPTH-th beat SHALL be treated as last and err_ovf SHALL be set.
REQ-013 In WAIT_MAX and DRAIN: in_ready=0, and in_valid SHALL be ignored.
REQ-014 max_valid SHALL be honoured only in WAIT_MAX, where it captures max_q78 into a register and enters DRAIN; outside WAIT_MAX it is ignored.
REQ-015 In DRAIN: elements SHALL be emitted in arrival order, with out_data = sat16(x - xmax) computed at 17-bit signed width and saturated to [16'h8000, 16'h7FFF].
REQ-016 First out_valid SHALL assert exactly 2 cycles after the max_valid capture cycle.
REQ-017 With out_ready held at 1, DRAIN SHALL sustain one beat per cycle with no bubbles.
REQ-018 out_valid/out_data/out_last SHALL be registered and held stable while out_valid=1 and out_ready=0 (no drop, no duplicate under any out_ready pattern).
REQ-019 out_last SHALL be 1 only on the count-th beat.
REQ-020 When the last beat is accepted, the FSM SHALL return to FILL with wr_ptr cleared; in_ready may assert the next cycle.
REQ-021 Single-element vectors SHALL work, yielding one output beat with out_last=1.

Reset
REQ-022 When rst_n=0 at a clock edge: state=FILL, wr_ptr=0, rd_ptr=0, out_valid=0, out_data=0, out_last=0, err_ovf=0, xmax=16'h8000, and in_ready=1 from the following cycle.
REQ-023 Reset in any state, including mid-DRAIN, SHALL abandon the vector; RAM contents need not be cleared.

Configuration
REQ-024 If macro MAX_SUB_CLAMP_EN is defined, any saturated difference below CLAMP_Q78 SHALL output CLAMP_Q78. Undefined: no clamp, and CLAMP_Q78 is unused.

Structure
REQ-025 Package softmax_pkg SHALL hold Q78_W=16, Q78_NEG_INF=16'h8000, Q78_MAX=16'h7FFF, the FSM state enum and the sat16 function.
REQ-026 Sub-module sm_vec_ram SHALL be a simple dual-port synchronous RAM (DEPTH x 16, 1-cycle read latency), instantiated once.

Verification
REQ-027 Input {0x0100, 0x0200, 0xFF80, 0x0200} with last on the 4th beat; max_valid with 0x0200 one cycle later -> out {0xFF00, 0x0000, 0xFD80, 0x0000}, out_last on the 4th, first out_valid 2 cycles after max_valid.
REQ-028 Input {0x8000} (last), max 0x7FFF -> out 0x8000 with the macro undefined, 0xF000 with MAX_SUB_CLAMP_EN defined; out_last=1.
REQ-029 4-element vector drained with out_ready toggling 1,0,0,1,0,1... -> each beat held stable while stalled; exactly 4 beats in order.
REQ-030 DEPTH=8, 10 beats with no in_last -> in_ready drops after beat 8, err_ovf=1, 8 outputs with out_last on the 8th; beats 9-10 are not accepted.
REQ-031 rst_n=0 for 1 cycle during beat 2 of DRAIN -> all outputs at reset values next cycle; a following 2-element vector processes correctly.
REQ-032 max_valid pulsed during FILL (before in_last) -> ignored: no capture, no state change.
